vocab_matcher: RTL and testbench
================================

# vocab_matcher

Parametrised successor to the single-mode token matcher. It searches a vocabulary memory of TERM-terminated words for the TERM-terminated input string. Exact mode returns the index of the first word equal to the input; longest-prefix mode returns the longest word that is a prefix of the input. It sits between the tokenizer's vocabulary RAM and input buffer, both synchronous-read with one-cycle latency, and reports its result through a start/done handshake with sticky result registers.

## Interface
- ADDR_WIDTH, 4, address width of both memories
- DATA_WIDTH, 8, symbol width
- IDX_WIDTH, 4, width of word index
- TERM, 0, terminator symbol value
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin search; sampled only in IDLE
- mode  in  1  0 = exact, 1 = longest prefix; latched at start
- vocab_start_addr, vocab_end_addr  in  ADDR_WIDTH each  vocabulary region [start, end); end exclusive; latched at start
- input_start_addr  in  ADDR_WIDTH  first input symbol; latched at start
- addr_v, addr_i  out  ADDR_WIDTH each  registered read addresses
- rd_en  out  1  read strobe to both memories
- val_vocab, val_input  in  DATA_WIDTH each  read data, valid the cycle after rd_en
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- found  out  1  result valid; sticky until next start
- match_idx  out  IDX_WIDTH  index of matched word (first word = 0); sticky
- match_len  out  ADDR_WIDTH  matched symbols excluding TERM; sticky
- err  out  1  malformed-data abort; sticky

## Operation
- States: IDLE, RD, CMP, SKIP_RD, SKIP_CMP, FIN.
- IDLE + start: latch config. addr_v <= vocab_start, addr_i <= input_start, clear idx, len, best and results. Go to RD, or to FIN if vocab_start == vocab_end.
- RD / SKIP_RD: rd_en = 1. Next state is CMP / SKIP_CMP, where data is valid.
- CMP, with v = val_vocab and i = val_input:
  - v == TERM, i == TERM: full match. Set found, match_idx = idx, match_len = len. Go to FIN. Applies in both modes.
  - v == TERM, i != TERM: word is a proper prefix of the input. In prefix mode, if len > best_len or no candidate exists, record candidate (idx, len). A len of 0 is never recorded. Then advance to the next word.
  - v != TERM and (i == TERM or v != i): mismatch. addr_v++ and go to SKIP_RD.
  - v == i != TERM: addr_v++, addr_i++, len++. Go to RD.
- Next word: addr_v++, addr_i <= input_start, len <= 0, idx++. Go to RD.
- SKIP_CMP: if v == TERM, take the next-word step; otherwise addr_v++ and go to SKIP_RD.
- Vocab overrun: check every addr_v increment against vocab_end.
  - At a word boundary (the next-word step), reaching vocab_end goes to FIN with no error.
  - Mid-word, reaching vocab_end sets err.
- Other errors: idx overflowing 2^IDX_WIDTH − 1 sets err; len saturating at 2^ADDR_WIDTH − 1 sets err.
- On err: found = 0, go to FIN.
- FIN:
  - If prefix mode, not found, no err and a candidate exists: found = 1 with the candidate's values.
  - Pulse done, drop busy, return to IDLE.
- start while busy is ignored. start in the FIN cycle is also ignored; it is accepted from IDLE on the next cycle.

## Timing
- Reset values: state IDLE; addr_v, addr_i, match_idx, match_len = 0; rd_en, busy, done, found, err = 0.
- Reset is asynchronous. Asserting it mid-search aborts to IDLE immediately with the reset values above; no done pulse is produced.
- The start edge is cycle 0. The first RD is cycle 1 and the first CMP is cycle 2.
- Each vocabulary address is fetched at most once per search, costing 2 cycles.
- done is asserted at most 2·(vocab_end − vocab_start) + 2 cycles after start.
- Results, found and err change only in FIN or in the start cycle. They are stable from done until the next accepted start.
- addr_v and addr_i change only on the clock edge leaving CMP, SKIP_CMP or IDLE. They are held stable through RD.
- Address arithmetic is modulo 2^ADDR_WIDTH. vocab_end < vocab_start is unsupported (err is not required).

## Structure
- Package vocab_matcher_pkg holds:
  - the state enum vm_state_t (IDLE … FIN);
  - the mode enum vm_mode_t (VM_EXACT = 0, VM_PREFIX = 1).
- TERM stays a module parameter.
- Single module, no sub-modules. The candidate register (valid, idx, len) is inline logic.

## Test plan
- Vocab "ab\0cd\0" (region 0–6), input "cd\0", exact → done with found = 1, match_idx = 1, match_len = 2, err = 0.
- Same vocab, input "ce\0", exact → found = 0, err = 0, done ≤ 14 cycles after start.
- Vocab "a\0abc\0ab\0", input "abcd\0", prefix → found = 1, match_idx = 1, match_len = 3. In exact mode, the same stimulus gives found = 0.
- Vocab "ab" with no TERM (region 0–2), input "ab\0" → err = 1, found = 0, done pulses once.
- vocab_start == vocab_end → done at cycle 1, found = 0; start asserted while busy → ignored, no second done.
- Assert rst_n low in the middle of a search → all outputs at reset values immediately; a new start afterwards completes normally.

Source files
------------

// File: rtl/vocab_matcher_pkg.sv
// Shared types for the vocabulary matcher: FSM state encoding and search mode.
package vocab_matcher_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD       = 3'd1,
      CMP      = 3'd2,
      SKIP_RD  = 3'd3,
      SKIP_CMP = 3'd4,
      FIN      = 3'd5
   } vm_state_t;

   typedef enum logic {
      VM_EXACT  = 1'b0,
      VM_PREFIX = 1'b1
   } vm_mode_t;

endpackage

// File: rtl/vocab_matcher.sv
// Walks a TERM-terminated vocabulary in a synchronous-read RAM and reports the first
// exact match or the longest word that prefixes the input string.
module vocab_matcher
   import vocab_matcher_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 4,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    IDX_WIDTH  = 4,
   parameter logic [DATA_WIDTH-1:0] TERM       = {DATA_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  mode,
   input  logic [ADDR_WIDTH-1:0] vocab_start_addr,
   input  logic [ADDR_WIDTH-1:0] vocab_end_addr,
   input  logic [ADDR_WIDTH-1:0] input_start_addr,
   output logic [ADDR_WIDTH-1:0] addr_v,
   output logic [ADDR_WIDTH-1:0] addr_i,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] val_vocab,
   input  logic [DATA_WIDTH-1:0] val_input,
   output logic                  busy,
   output logic                  done,
   output logic                  found,
   output logic [IDX_WIDTH-1:0]  match_idx,
   output logic [ADDR_WIDTH-1:0] match_len,
   output logic                  err
);

   localparam logic [ADDR_WIDTH-1:0] A_ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] A_ZERO  = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] LEN_MAX = {ADDR_WIDTH{1'b1}};
   localparam logic [IDX_WIDTH-1:0]  I_ONE   = IDX_WIDTH'(1);
   localparam logic [IDX_WIDTH-1:0]  I_ZERO  = {IDX_WIDTH{1'b0}};
   localparam logic [IDX_WIDTH-1:0]  IDX_MAX = {IDX_WIDTH{1'b1}};

   vm_state_t             state_q, state_d;
   vm_mode_t              mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] vend_q, vend_d;
   logic [ADDR_WIDTH-1:0] istart_q, istart_d;
   logic [ADDR_WIDTH-1:0] addr_v_q, addr_v_d;
   logic [ADDR_WIDTH-1:0] addr_i_q, addr_i_d;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;
   logic                  cand_valid_q, cand_valid_d;
   logic [IDX_WIDTH-1:0]  cand_idx_q, cand_idx_d;
   logic [ADDR_WIDTH-1:0] cand_len_q, cand_len_d;
   logic                  found_q, found_d;
   logic [IDX_WIDTH-1:0]  match_idx_q, match_idx_d;
   logic [ADDR_WIDTH-1:0] match_len_q, match_len_d;
   logic                  err_q, err_d;
   logic                  rd_en_q, rd_en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  v_term_s;
   logic                  i_term_s;
   logic                  sym_eq_s;
   logic [ADDR_WIDTH-1:0] addr_v_inc_s;
   logic                  next_word_s;
   logic                  cand_rec_s;

   assign v_term_s     = (val_vocab == TERM);
   assign i_term_s     = (val_input == TERM);
   assign sym_eq_s     = (val_vocab == val_input);
   assign addr_v_inc_s = addr_v_q + A_ONE;

   // A word ends either as a proper prefix of the input (CMP) or after a mismatch skip.
   assign next_word_s  = v_term_s && (((state_q == CMP) && !i_term_s) || (state_q == SKIP_CMP));
   assign cand_rec_s   = next_word_s && (state_q == CMP) && (mode_q == VM_PREFIX) &&
                         (len_q != A_ZERO) && (!cand_valid_q || (len_q > cand_len_q));

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      vend_d       = vend_q;
      istart_d     = istart_q;
      addr_v_d     = addr_v_q;
      addr_i_d     = addr_i_q;
      idx_d        = idx_q;
      len_d        = len_q;
      cand_valid_d = cand_valid_q;
      cand_idx_d   = cand_idx_q;
      cand_len_d   = cand_len_q;
      found_d      = found_q;
      match_idx_d  = match_idx_q;
      match_len_d  = match_len_q;
      err_d        = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d       = vm_mode_t'(mode);
               vend_d       = vocab_end_addr;
               istart_d     = input_start_addr;
               addr_v_d     = vocab_start_addr;
               addr_i_d     = input_start_addr;
               idx_d        = I_ZERO;
               len_d        = A_ZERO;
               cand_valid_d = 1'b0;
               cand_idx_d   = I_ZERO;
               cand_len_d   = A_ZERO;
               found_d      = 1'b0;
               match_idx_d  = I_ZERO;
               match_len_d  = A_ZERO;
               err_d        = 1'b0;
               state_d      = (vocab_start_addr == vocab_end_addr) ? FIN : RD;
            end else begin
               state_d = IDLE;
            end
         end
         RD:      state_d = CMP;
         SKIP_RD: state_d = SKIP_CMP;
         CMP, SKIP_CMP: begin
            if (next_word_s) begin
               if (cand_rec_s) begin
                  cand_valid_d = 1'b1;
                  cand_idx_d   = idx_q;
                  cand_len_d   = len_q;
               end else begin
                  cand_valid_d = cand_valid_q;
               end
               // Running off the region exactly at a word boundary is a clean end of search.
               if (addr_v_inc_s == vend_q) begin
                  state_d = FIN;
                  if ((mode_q == VM_PREFIX) && cand_valid_d) begin
                     found_d     = 1'b1;
                     match_idx_d = cand_idx_d;
                     match_len_d = cand_len_d;
                  end else begin
                     found_d = 1'b0;
                  end
               end else if (idx_q == IDX_MAX) begin
                  err_d   = 1'b1;
                  found_d = 1'b0;
                  state_d = FIN;
               end else begin
                  addr_v_d = addr_v_inc_s;
                  addr_i_d = istart_q;
                  len_d    = A_ZERO;
                  idx_d    = idx_q + I_ONE;
                  state_d  = RD;
               end
            end else if (v_term_s) begin
               found_d     = 1'b1;
               match_idx_d = idx_q;
               match_len_d = len_q;
               state_d     = FIN;
            end else if ((state_q == SKIP_CMP) || i_term_s || !sym_eq_s) begin
               if (addr_v_inc_s == vend_q) begin
                  err_d   = 1'b1;
                  found_d = 1'b0;
                  state_d = FIN;
               end else begin
                  addr_v_d = addr_v_inc_s;
                  state_d  = SKIP_RD;
               end
            end else begin
               if ((addr_v_inc_s == vend_q) || (len_q == (LEN_MAX - A_ONE))) begin
                  err_d   = 1'b1;
                  found_d = 1'b0;
                  state_d = FIN;
               end else begin
                  addr_v_d = addr_v_inc_s;
                  addr_i_d = addr_i_q + A_ONE;
                  len_d    = len_q + A_ONE;
                  state_d  = RD;
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      rd_en_d = (state_d == RD) || (state_d == SKIP_RD);
      busy_d  = (state_d != IDLE) && (state_d != FIN);
      done_d  = (state_d == FIN);
   end

   // State and output registers; reset aborts any search without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         mode_q       <= VM_EXACT;
         vend_q       <= A_ZERO;
         istart_q     <= A_ZERO;
         addr_v_q     <= A_ZERO;
         addr_i_q     <= A_ZERO;
         idx_q        <= I_ZERO;
         len_q        <= A_ZERO;
         cand_valid_q <= 1'b0;
         cand_idx_q   <= I_ZERO;
         cand_len_q   <= A_ZERO;
         found_q      <= 1'b0;
         match_idx_q  <= I_ZERO;
         match_len_q  <= A_ZERO;
         err_q        <= 1'b0;
         rd_en_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         vend_q       <= vend_d;
         istart_q     <= istart_d;
         addr_v_q     <= addr_v_d;
         addr_i_q     <= addr_i_d;
         idx_q        <= idx_d;
         len_q        <= len_d;
         cand_valid_q <= cand_valid_d;
         cand_idx_q   <= cand_idx_d;
         cand_len_q   <= cand_len_d;
         found_q      <= found_d;
         match_idx_q  <= match_idx_d;
         match_len_q  <= match_len_d;
         err_q        <= err_d;
         rd_en_q      <= rd_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign addr_v    = addr_v_q;
   assign addr_i    = addr_i_q;
   assign rd_en     = rd_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign found     = found_q;
   assign match_idx = match_idx_q;
   assign match_len = match_len_q;
   assign err       = err_q;

endmodule

// File: tb/tb_vocab_matcher.sv
// Directed scoreboard bench for vocab_matcher: expected results are queued at start
// and compared when done pulses.
module tb_vocab_matcher;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int IW = 4;
   localparam logic [7:0] DOT    = 8'h2E;
   localparam logic [7:0] FILLER = 8'h7F;

   typedef struct {
      logic          found;
      logic [IW-1:0] idx;
      logic [AW-1:0] len;
      logic          err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          mode;
   logic [AW-1:0] vsa, vea, isa;
   logic [AW-1:0] addr_v, addr_i;
   logic          rd_en;
   logic [DW-1:0] val_vocab, val_input;
   logic          busy, done, found, err;
   logic [IW-1:0] match_idx;
   logic [AW-1:0] match_len;

   logic [DW-1:0] vmem [0:15];
   logic [DW-1:0] imem [0:15];

   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   done_cnt  = 0;
   exp_t sb_q[$];

   vocab_matcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .TERM(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .vocab_start_addr(vsa), .vocab_end_addr(vea), .input_start_addr(isa),
      .addr_v(addr_v), .addr_i(addr_i), .rd_en(rd_en),
      .val_vocab(val_vocab), .val_input(val_input),
      .busy(busy), .done(done), .found(found),
      .match_idx(match_idx), .match_len(match_len), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en === 1'b1) begin
         val_vocab <= vmem[addr_v];
         val_input <= imem[addr_i];
      end
   end

   always @(posedge clk) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   function automatic exp_t mk(input logic f, input int i, input int l, input logic e);
      exp_t r;
      r.found = f;
      r.idx   = IW'(i);
      r.len   = AW'(l);
      r.err   = e;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // '.' in the string stands for TERM
   task automatic load(input bit to_vocab, input int base, input string s);
      logic [7:0] c;
      for (int k = 0; k < 16; k++) begin
         if (to_vocab) vmem[k] = FILLER;
         else imem[k] = FILLER;
      end
      for (int k = 0; k < s.len(); k++) begin
         c = s[k];
         if (c == DOT) c = 8'h00;
         if (to_vocab) vmem[(base + k) % 16] = c;
         else imem[(base + k) % 16] = c;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".addr_v"}, 32'(addr_v), 32'd0);
      check({tag, ".addr_i"}, 32'(addr_i), 32'd0);
      check({tag, ".rd_en"}, 32'(rd_en), 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd0);
      check({tag, ".done"}, 32'(done), 32'd0);
      check({tag, ".found"}, 32'(found), 32'd0);
      check({tag, ".match_idx"}, 32'(match_idx), 32'd0);
      check({tag, ".match_len"}, 32'(match_len), 32'd0);
      check({tag, ".err"}, 32'(err), 32'd0);
   endtask

   task automatic run_search(input string tag, input logic m, input logic [AW-1:0] vs,
                             input logic [AW-1:0] ve, input logic [AW-1:0] is,
                             input exp_t e, input int poke_cyc, output int cyc);
      int   d0;
      int   bound;
      exp_t want;
      bound = 2 * int'(AW'(ve - vs)) + 2;
      d0 = done_cnt;
      sb_q.push_back(e);
      @(negedge clk);
      mode = m; vsa = vs; vea = ve; isa = is; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (done !== 1'b1 && cyc < 64) begin
         if (cyc == poke_cyc) begin
            start = 1'b1;
            vea = vs;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check({tag, ".done_seen"}, 32'(done), 32'd1);
      check({tag, ".latency_ok"}, 32'(cyc <= bound), 32'd1);
      want = sb_q.pop_front();
      check({tag, ".found"}, 32'(found), 32'(want.found));
      check({tag, ".match_idx"}, 32'(match_idx), 32'(want.idx));
      check({tag, ".match_len"}, 32'(match_len), 32'(want.len));
      check({tag, ".err"}, 32'(err), 32'(want.err));
      repeat (6) @(negedge clk);
      check({tag, ".done_once"}, 32'(done_cnt - d0), 32'd1);
      check({tag, ".sticky_found"}, 32'(found), 32'(want.found));
   endtask

   initial begin
      int cyc;
      int d0;
      rst_n = 1'b0; start = 1'b0; mode = 1'b0;
      vsa = '0; vea = '0; isa = '0;
      load(1'b1, 0, "");
      load(1'b0, 0, "");
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      load(1'b1, 0, "ab.cd.");
      load(1'b0, 0, "cd.");
      run_search("exact_cd", 1'b0, 4'd0, 4'd6, 4'd0, mk(1'b1, 1, 2, 1'b0), 0, cyc);

      load(1'b0, 5, "ce.");
      run_search("exact_ce", 1'b0, 4'd0, 4'd6, 4'd5, mk(1'b0, 0, 0, 1'b0), 0, cyc);
      check("exact_ce.cycles_le_14", 32'(cyc <= 14), 32'd1);

      load(1'b1, 0, "a.abc.ab.");
      load(1'b0, 0, "abcd.");
      run_search("prefix_abcd", 1'b1, 4'd0, 4'd9, 4'd0, mk(1'b1, 1, 3, 1'b0), 0, cyc);
      run_search("exact_abcd", 1'b0, 4'd0, 4'd9, 4'd0, mk(1'b0, 0, 0, 1'b0), 0, cyc);

      load(1'b1, 3, "a.ab.");
      load(1'b0, 2, "ab.");
      run_search("prefix_full_wins", 1'b1, 4'd3, 4'd8, 4'd2, mk(1'b1, 1, 2, 1'b0), 0, cyc);

      load(1'b1, 0, "ab");
      load(1'b0, 0, "ab.");
      run_search("no_term_err", 1'b0, 4'd0, 4'd2, 4'd0, mk(1'b0, 0, 0, 1'b1), 0, cyc);

      run_search("empty_region", 1'b0, 4'd3, 4'd3, 4'd0, mk(1'b0, 0, 0, 1'b0), 0, cyc);
      check("empty_region.done_cycle", 32'(cyc), 32'd1);

      load(1'b1, 0, "ab.cd.");
      load(1'b0, 0, "cd.");
      run_search("start_while_busy", 1'b0, 4'd0, 4'd6, 4'd0, mk(1'b1, 1, 2, 1'b0), 3, cyc);

      d0 = done_cnt;
      @(negedge clk);
      mode = 1'b0; vsa = 4'd0; vea = 4'd6; isa = 4'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      repeat (2) @(negedge clk);
      check("mid_reset.no_done", 32'(done_cnt - d0), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run_search("after_reset", 1'b0, 4'd0, 4'd6, 4'd0, mk(1'b1, 1, 2, 1'b0), 0, cyc);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
